dvp_frame_ctrl: RTL and testbench

Frame-capture sequencer in the AXIS clock domain, placed between the DVP-to-AXIS capture FIFO output and the S2MM DMA input. It drives the capture-enable level back to the DVP path and flushes stale FIFO contents before each capture. It forwards exactly `i_frame_beats` beats per frame and generates `m_axis_tlast`. It supports single-shot and continuous capture, stop at the frame boundary, immediate abort, and a mid-frame stall timeout.

---
 rtl/dvp_frame_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_dvp_frame_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dvp_frame_ctrl
// Description : Frame-capture sequencer between the DVP capture FIFO and the
//               S2MM DMA: flush, frame-length tlast generation, stop/abort/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module dvp_frame_ctrl #(
    parameter int P_AXIS_DATA_WIDTH = 64,
    parameter int P_BEATS_WIDTH     = 24,
    parameter int P_FLUSH_IDLE      = 16,
    parameter int P_TIMEOUT         = 2**20,
    parameter int C_TO_WIDTH        = $clog2(P_TIMEOUT) + 1
) (
    input  logic                         i_axis_clk,
    input  logic                         i_axis_rst,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_abort,
    input  logic                         i_continuous,
    input  logic [P_BEATS_WIDTH-1:0]     i_frame_beats,
    input  logic                         i_clr_err,
    output logic                         o_cap_ena,
    output logic [1:0]                   o_state,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic [31:0]                  o_frame_cnt,
    output logic [P_BEATS_WIDTH-1:0]     o_beat_cnt,
    output logic                         o_err_timeout,
    output logic                         o_err_cfg,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [P_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [P_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tlast
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    localparam int                    C_FL_WIDTH = $clog2(P_FLUSH_IDLE + 1);
    localparam logic [C_FL_WIDTH-1:0] C_FL_LAST  = C_FL_WIDTH'(P_FLUSH_IDLE - 1);
    localparam logic [C_TO_WIDTH-1:0] C_TO_LAST  = C_TO_WIDTH'(P_TIMEOUT - 1);

    logic [1:0]               state_q, state_d;
    logic [P_BEATS_WIDTH-1:0] len_q, len_d;
    logic [P_BEATS_WIDTH-1:0] beat_q, beat_d;
    logic [C_FL_WIDTH-1:0]    fl_q, fl_d;
    logic [C_TO_WIDTH-1:0]    to_q, to_d;
    logic [31:0]              frame_cnt_q, frame_cnt_d;
    logic                     cont_q, cont_d;
    logic                     stop_pend_q, stop_pend_d;
    logic                     done_q, done_d;
    logic                     err_to_q, err_to_d;
    logic                     err_cfg_q, err_cfg_d;
    logic                     cap_ena_q, cap_ena_d;

    logic w_run, w_acc, w_last, w_last_acc, w_timeout, w_start_ok, w_flush_done;

    assign w_run        = (state_q == S_RUN);
    assign w_acc        = s_axis_tvalid & m_axis_tready;
    assign w_last       = (beat_q == len_q - 1'b1);
    assign w_last_acc   = w_run & w_acc & w_last;
    // No timeout before the first beat of a frame has been accepted.
    assign w_timeout    = w_run & (beat_q != '0) & ~w_acc & (to_q == C_TO_LAST);
    assign w_start_ok   = (state_q == S_IDLE) & i_start & (i_frame_beats != '0);
    assign w_flush_done = (state_q == S_FLUSH) & ~s_axis_tvalid & (fl_q == C_FL_LAST);

    always_ff @(posedge i_axis_clk) begin : p_state_reg
        if (i_axis_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (w_start_ok) state_d = S_FLUSH;
                S_FLUSH: begin
                    if (i_stop)            state_d = S_IDLE;
                    else if (w_flush_done) state_d = S_RUN;
                end
                S_RUN: begin
                    if (w_timeout) begin
                        state_d = S_IDLE;
                    end else if (w_last_acc && (!cont_q || stop_pend_q || i_stop)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin : p_outputs
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        if (w_run) begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
            m_axis_tlast  = w_last;
        end
    end

    always_comb begin : p_datapath
        len_d       = len_q;
        cont_d      = cont_q;
        fl_d        = fl_q;
        beat_d      = beat_q;
        to_d        = to_q;
        stop_pend_d = stop_pend_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    len_d  = i_frame_beats;
                    cont_d = i_continuous;
                    fl_d   = '0;
                end
            end
            S_FLUSH: begin
                fl_d        = s_axis_tvalid ? '0 : fl_q + 1'b1;
                beat_d      = '0;
                to_d        = '0;
                stop_pend_d = 1'b0;
            end
            S_RUN: begin
                if (i_stop) stop_pend_d = 1'b1;
                if (w_acc) begin
                    to_d = '0;
                    if (w_last) begin
                        beat_d      = '0;
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        done_d      = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (beat_q != '0) begin
                    to_d = to_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (state_d == S_IDLE) begin
            beat_d      = '0;
            to_d        = '0;
            stop_pend_d = 1'b0;
        end
        // Abort drops the frame even if its tlast beat handshakes this cycle.
        if (i_abort) begin
            frame_cnt_d = frame_cnt_q;
            done_d      = 1'b0;
        end
        err_to_d  = (w_timeout & ~i_abort) | (err_to_q & ~i_clr_err);
        err_cfg_d = ((state_q == S_IDLE) & i_start & (i_frame_beats == '0) & ~i_abort)
                  | (err_cfg_q & ~i_clr_err);
        cap_ena_d = (state_d == S_RUN);
    end

    always_ff @(posedge i_axis_clk) begin : p_datapath_reg
        if (i_axis_rst) begin
            len_q       <= '0;
            cont_q      <= 1'b0;
            fl_q        <= '0;
            beat_q      <= '0;
            to_q        <= '0;
            stop_pend_q <= 1'b0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            err_to_q    <= 1'b0;
            err_cfg_q   <= 1'b0;
            cap_ena_q   <= 1'b0;
        end else begin
            len_q       <= len_d;
            cont_q      <= cont_d;
            fl_q        <= fl_d;
            beat_q      <= beat_d;
            to_q        <= to_d;
            stop_pend_q <= stop_pend_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            err_to_q    <= err_to_d;
            err_cfg_q   <= err_cfg_d;
            cap_ena_q   <= cap_ena_d;
        end
    end

    assign o_cap_ena     = cap_ena_q;
    assign o_state       = state_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_frame_done  = done_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_beat_cnt    = beat_q;
    assign o_err_timeout = err_to_q;
    assign o_err_cfg     = err_cfg_q;

endmodule
`default_nettype wire

// File: tb/tb_dvp_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dvp_frame_ctrl
// Description : Directed scoreboard bench for dvp_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dvp_frame_ctrl;

    localparam int DW = 16;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0, i_stop = 1'b0, i_abort = 1'b0;
    logic          i_continuous = 1'b0, i_clr_err = 1'b0;
    logic [BW-1:0] i_frame_beats = '0;
    logic          o_cap_ena, o_busy, o_frame_done, o_err_timeout, o_err_cfg;
    logic [1:0]    o_state;
    logic [31:0]   o_frame_cnt;
    logic [BW-1:0] o_beat_cnt;
    logic          s_axis_tvalid = 1'b0, s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          m_axis_tvalid, m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] m_axis_tdata;

    int            checks = 0;
    int            errors = 0;
    bit            rand_rdy = 1'b0;
    logic [DW:0]   sb[$];

    dvp_frame_ctrl #(
        .P_AXIS_DATA_WIDTH(DW),
        .P_BEATS_WIDTH    (BW),
        .P_FLUSH_IDLE     (16),
        .P_TIMEOUT        (100)
    ) dut (
        .i_axis_clk   (clk),
        .i_axis_rst   (rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_abort      (i_abort),
        .i_continuous (i_continuous),
        .i_frame_beats(i_frame_beats),
        .i_clr_err    (i_clr_err),
        .o_cap_ena    (o_cap_ena),
        .o_state      (o_state),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_frame_cnt  (o_frame_cnt),
        .o_beat_cnt   (o_beat_cnt),
        .o_err_timeout(o_err_timeout),
        .o_err_cfg    (o_err_cfg),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast)
    );

    always #5 clk = ~clk;

    // Monitor: every output handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got last=%0b data=%h, none expected",
                         m_axis_tlast, m_axis_tdata);
            end else begin
                logic [DW:0] exp_beat;
                exp_beat = sb.pop_front();
                if ({m_axis_tlast, m_axis_tdata} !== exp_beat) begin
                    errors++;
                    $display("FAIL beat got last=%0b data=%h, expected last=%0b data=%h",
                             m_axis_tlast, m_axis_tdata, exp_beat[DW], exp_beat[DW-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_stop  = 1'b0;
        i_abort = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        rand_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_cap(input logic [BW-1:0] beats, input bit cont);
        i_frame_beats = beats;
        i_continuous  = cont;
        i_start       = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (o_state != 2'd2 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Present one source beat until it is taken; fwd means it must reach the DMA.
    task automatic send(input logic [DW-1:0] d, input bit last, input bit fwd);
        bit hs;
        int n;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        if (fwd) sb.push_back({last, d});
        n = 0;
        do begin
            if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = s_axis_tready;
            tick();
            n++;
        end while (!hs && n < 50);
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout beat %h not accepted in 50 cycles", d);
        end
        s_axis_tvalid = 1'b0;
        if (rand_rdy) m_axis_tready = 1'b1;
    endtask

    initial begin
        int n;
        do_reset();
        chk("rst_state", 32'(o_state), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_cap_ena", 32'(o_cap_ena), 0);
        chk("rst_s_tready", 32'(s_axis_tready), 1);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_frame_cnt", o_frame_cnt, 0);
        chk("rst_errs", {30'd0, o_err_timeout, o_err_cfg}, 0);

        // Single shot, 4 beats
        start_cap(8'd4, 1'b0);
        chk("flush_state", 32'(o_state), 1);
        wait_run(n);
        chk("flush_len_idle", 32'(n), 16);
        chk("run_cap_ena", 32'(o_cap_ena), 1);
        for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i), i == 3, 1'b1);
        chk("t1_done", 32'(o_frame_done), 1);
        chk("t1_frame_cnt", o_frame_cnt, 1);
        chk("t1_state", 32'(o_state), 0);
        chk("t1_cap_ena", 32'(o_cap_ena), 0);
        tick();
        chk("t1_done_pulse", 32'(o_frame_done), 0);

        // Continuous, length 3, stop during beat 5
        do_reset();
        start_cap(8'd3, 1'b1);
        wait_run(n);
        rand_rdy = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i == 5) i_stop = 1'b1;
            send(16'h0200 + 16'(i), (i % 3) == 0, i <= 6);
            if (i == 3) begin
                chk("t2_done_f1", 32'(o_frame_done), 1);
                chk("t2_state_f1", 32'(o_state), 2);
            end
            if (i == 6) chk("t2_state_f2", 32'(o_state), 0);
        end
        rand_rdy = 1'b0;
        chk("t2_frame_cnt", o_frame_cnt, 2);

        // Flush sees 40 cycles of valid source data
        do_reset();
        start_cap(8'd2, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hDEAD;
        repeat (40) tick();
        chk("t3_still_flush", 32'(o_state), 1);
        s_axis_tvalid = 1'b0;
        wait_run(n);
        chk("t3_idle_to_run", 32'(n), 16);
        send(16'h0301, 1'b0, 1'b1);
        send(16'h0302, 1'b1, 1'b1);
        chk("t3_frame_cnt", o_frame_cnt, 1);

        // Mid-frame stall timeout
        do_reset();
        start_cap(8'd8, 1'b0);
        wait_run(n);
        send(16'h0401, 1'b0, 1'b1);
        send(16'h0402, 1'b0, 1'b1);
        n = 0;
        while (!o_err_timeout && n < 300) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", 32'(n), 100);
        chk("t4_state", 32'(o_state), 0);
        chk("t4_frame_cnt", o_frame_cnt, 0);
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        chk("t4_clr_err", 32'(o_err_timeout), 0);

        // Abort coincident with the tlast handshake
        do_reset();
        start_cap(8'd2, 1'b0);
        wait_run(n);
        send(16'h0501, 1'b0, 1'b1);
        i_abort = 1'b1;
        send(16'h0502, 1'b1, 1'b1);
        chk("t5_state", 32'(o_state), 0);
        chk("t5_frame_cnt", o_frame_cnt, 0);
        chk("t5_no_done", 32'(o_frame_done), 0);
        chk("t5_beat_cnt", 32'(o_beat_cnt), 0);

        // Zero-length start, then reset mid-RUN
        do_reset();
        start_cap(8'd0, 1'b0);
        chk("t6_state", 32'(o_state), 0);
        chk("t6_err_cfg", 32'(o_err_cfg), 1);
        chk("t6_cap_ena", 32'(o_cap_ena), 0);
        start_cap(8'd4, 1'b0);
        wait_run(n);
        send(16'h0601, 1'b0, 1'b1);
        chk("t6_beat_cnt", 32'(o_beat_cnt), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_state", 32'(o_state), 0);
        chk("t6_rst_cap_ena", 32'(o_cap_ena), 0);
        chk("t6_rst_beat_cnt", 32'(o_beat_cnt), 0);
        chk("t6_rst_err_cfg", 32'(o_err_cfg), 0);
        chk("t6_rst_s_tready", 32'(s_axis_tready), 1);
        chk("t6_rst_m_tvalid", 32'(m_axis_tvalid), 0);

        // Maximum frame length 2^BW-1
        do_reset();
        start_cap(8'd255, 1'b0);
        wait_run(n);
        for (int i = 0; i < 255; i++) send(16'h7000 + 16'(i), i == 254, 1'b1);
        chk("t7_frame_cnt", o_frame_cnt, 1);
        chk("t7_state", 32'(o_state), 0);

        tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
